set_initiator: RTL and testbench

Host-side initiator for the SET point-counting engine. It accepts set-query jobs (centres, radii, mode) from an upstream valid/ready stream and buffers them in a small FIFO. It issues each job to SET with the correct `en`/operand hold protocol, captures `candidate` on SET's one-cycle `valid` pulse, and returns results on a downstream valid/ready stream. It sits between the job scheduler and the SET instance and guards against a hung engine with a timeout.

---
 rtl/set_pkg.sv | 30 +++
 rtl/set_job_fifo.sv | 51 +++++
 rtl/set_initiator.sv | 161 ++++++++++++++++
 tb/tb_set_initiator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// Shared definitions for the SET initiator: operand widths, mode encodings,
// job record layout and the initiator FSM state type.
package set_pkg;

  localparam int unsigned COORD_W   = 4;
  localparam int unsigned CENTRAL_W = 24;
  localparam int unsigned RADIUS_W  = 12;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned CAND_W    = 8;
  localparam int unsigned JOB_W     = CENTRAL_W + RADIUS_W + MODE_W;

  localparam logic [MODE_W-1:0] MODE_A   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_AND = 2'd1;
  localparam logic [MODE_W-1:0] MODE_XOR = 2'd2;
  localparam logic [MODE_W-1:0] MODE_TWO = 2'd3;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } set_job_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_RESP
  } set_state_e;

endpackage

// File: rtl/set_job_fifo.sv
// Synchronous job FIFO with registered occupancy count; head is read
// combinationally from storage, so a push is visible one cycle later.
module set_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 38,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/set_initiator.sv
// Host-side initiator for the SET engine: buffers jobs, issues them one at a
// time with held operands, captures the count or aborts on timeout.
module set_initiator
  import set_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [CENTRAL_W-1:0] job_central,
  input  logic [RADIUS_W-1:0]  job_radius,
  input  logic [MODE_W-1:0]    job_mode,
  output logic                 en,
  output logic [CENTRAL_W-1:0] central,
  output logic [RADIUS_W-1:0]  radius,
  output logic [MODE_W-1:0]    mode,
  input  logic                 busy,
  input  logic                 valid,
  input  logic [CAND_W-1:0]    candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CAND_W-1:0]    res_candidate,
  output logic                 res_err,
  output logic [15:0]          jobs_done
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  // Counter is 0 in the first HOLD cycle, so TIMEOUT-1 there is TIMEOUT cycles after en.
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  set_state_e           state_q, state_d;
  logic                 en_q, en_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic                 res_valid_q, res_valid_d;
  logic [CAND_W-1:0]    res_cand_q, res_cand_d;
  logic                 res_err_q, res_err_d;
  logic [15:0]          jobs_done_q, jobs_done_d;
  logic [7:0]           tmo_q, tmo_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [JOB_W-1:0]     fifo_rdata;
  logic [CNT_W-1:0]     fifo_count;
  set_job_t             head;
  logic                 busy_unused;

  assign busy_unused = busy;
  assign head        = set_job_t'(fifo_rdata);

  set_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (JOB_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (job_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({job_central, job_radius, job_mode}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assert property (@(posedge clk) disable iff (!rst) fifo_count <= CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    central_d   = central_q;
    radius_d    = radius_q;
    mode_d      = mode_q;
    res_valid_d = res_valid_q;
    res_cand_d  = res_cand_q;
    res_err_d   = res_err_q;
    jobs_done_d = jobs_done_q;
    tmo_d       = tmo_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d   = ST_ISSUE;
          en_d      = 1'b1;
          central_d = head.central;
          radius_d  = head.radius;
          mode_d    = head.mode;
          fifo_pop  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_HOLD;
        tmo_d   = '0;
      end
      ST_HOLD: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 8'd1;
        if (valid) begin
          state_d     = ST_RESP;
          res_valid_d = 1'b1;
          res_cand_d  = candidate;
          res_err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_RESP;
          res_valid_d = 1'b1;
          res_cand_d  = '0;
          res_err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          jobs_done_d = jobs_done_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_err_q   <= 1'b0;
      jobs_done_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      central_q   <= central_d;
      radius_q    <= radius_d;
      mode_q      <= mode_d;
      res_valid_q <= res_valid_d;
      res_cand_q  <= res_cand_d;
      res_err_q   <= res_err_d;
      jobs_done_q <= jobs_done_d;
      tmo_q       <= tmo_d;
    end
  end

  assign job_ready     = !fifo_full;
  assign en            = en_q;
  assign central       = central_q;
  assign radius        = radius_q;
  assign mode          = mode_q;
  assign res_valid     = res_valid_q;
  assign res_candidate = res_cand_q;
  assign res_err       = res_err_q;
  assign jobs_done     = jobs_done_q;

endmodule

// File: tb/tb_set_initiator.sv
// Scoreboard bench for set_initiator with a behavioural SET engine model.
module tb_set_initiator;
  import set_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy, valid;
  logic [7:0]  candidate;
  logic        res_valid, res_ready, res_err;
  logic [7:0]  res_candidate;
  logic [15:0] jobs_done;

  always #5 clk = ~clk;

  set_initiator #(.FIFO_DEPTH(4), .TIMEOUT(127)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
    .en(en), .central(central), .radius(radius), .mode(mode),
    .busy(busy), .valid(valid), .candidate(candidate),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_candidate(res_candidate), .res_err(res_err), .jobs_done(jobs_done)
  );

  typedef struct packed { int cand; int err; int lat; } exp_t;
  exp_t exp_q[$];
  bit   stall_q[$];

  int pass_cnt = 0, tot_cnt = 0, proto_err = 0, en_cnt = 0, cyc = 0;
  bit inject = 0, bp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Reference: count grid points (0..15)^2 satisfying the mode over circles A,B,C.
  function automatic int ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int n = 0;
    int cx[3], cy[3], rr[3];
    for (int k = 0; k < 3; k++) begin
      cx[k] = int'(c[23-8*k -: 4]);
      cy[k] = int'(c[19-8*k -: 4]);
      rr[k] = int'(r[11-4*k -: 4]);
    end
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        int in[3];
        for (int k = 0; k < 3; k++)
          in[k] = ((x-cx[k])*(x-cx[k]) + (y-cy[k])*(y-cy[k]) <= rr[k]*rr[k]) ? 1 : 0;
        case (m)
          2'd0: n += in[0];
          2'd1: n += in[0] & in[1];
          2'd2: n += in[0] ^ in[1];
          default: n += (in[0] + in[1] + in[2] == 2) ? 1 : 0;
        endcase
      end
    return n % 256;
  endfunction

  // Behavioural SET engine: result valid 67 cycles after en unless stalled.
  initial begin
    logic [37:0] snap;
    int cd;
    bit active, stl;
    valid = 0; busy = 0; candidate = 0; active = 0; stl = 0; cd = 0; snap = '0;
    forever begin
      @(negedge clk);
      valid = 0;
      if (!rst) begin
        active = 0; busy = 0;
      end else begin
        if (inject) begin valid = 1; candidate = 8'hAA; inject = 0; end
        if (en) begin
          active = 1; busy = 1; cd = 67;
          stl = (stall_q.size() > 0) ? stall_q.pop_front() : 1'b0;
          snap = {central, radius, mode};
        end else if (active) begin
          if ({central, radius, mode} !== snap) proto_err++;
          if (stl) begin
            if (res_valid) begin active = 0; busy = 0; end
          end else begin
            cd--;
            if (cd == 0) begin
              valid = 1; active = 0; busy = 0;
              candidate = 8'(ref_count(snap[37:14], snap[13:2], snap[1:0]));
            end
          end
        end
      end
    end
  end

  // Monitor: protocol watch on en, scoreboard compare on each new result.
  initial begin
    int last_en, consumed;
    bit have_en, prev_en, pend;
    exp_t e;
    last_en = 0; consumed = 0; have_en = 0; prev_en = 0; pend = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        have_en = 0; prev_en = 0; pend = 0; consumed = 0;
      end else begin
        if (en) begin
          if (prev_en) proto_err++;
          if (have_en && (cyc - last_en) < 68) proto_err++;
          if (res_valid) proto_err++;
          en_cnt++; last_en = cyc; have_en = 1;
        end
        prev_en = en;
        if (res_valid && !pend) begin
          pend = 1;
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("res_candidate", res_candidate, e.cand);
            chk("res_err", res_err, e.err);
            chk("latency_en_to_res", cyc - last_en, e.lat);
            chk("jobs_done_at_result", jobs_done, consumed);
          end
        end
        if (res_valid && res_ready) begin pend = 0; consumed++; end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_en) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                          input bit stall, input int cand_req);
    bit ok = 0, rdy;
    exp_t e;
    job_central = c; job_radius = r; job_mode = m; job_valid = 1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); rdy = job_ready;
      @(posedge clk); if (rdy) ok = 1;
    end
    if (!ok) chk("push_accept", 0, 1);
    else begin
      e.cand = stall ? 0 : cand_req;
      e.err  = stall ? 1 : 0;
      e.lat  = stall ? 128 : 68;
      exp_q.push_back(e);
      stall_q.push_back(stall);
    end
    #1 job_valid = 0;
  endtask

  task automatic push_rand(input logic [1:0] m, input bit stall);
    logic [23:0] c = 24'($urandom);
    logic [11:0] r = 12'($urandom);
    push_job(c, r, m, stall, ref_count(c, r, m));
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) done = 1;
    end
    if (!done) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_en(input int base, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (en_cnt > base) seen = 1;
    end
    if (!seen) chk("en_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_central"}, central, 0);
    chk({tag, "_radius"}, radius, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_job_ready"}, job_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_candidate"}, res_candidate, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  initial begin
    int base, jd;
    bit acc, stable;
    logic [7:0] sc;
    logic se;
    rst = 0; job_valid = 0; job_central = '0; job_radius = '0; job_mode = '0; res_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    rst = 1;
    @(posedge clk); #1;

    // Directed single job: circle A at (4,4) radius 3 covers 29 grid points.
    push_job(24'h444444, 12'h333, MODE_A, 0, 29);
    wait_drain(400);
    chk("single_jobs_done", jobs_done, 1);
    chk("single_en_pulses", en_cnt, 1);

    // Lead job in flight, then fill the FIFO with four back-to-back jobs.
    base = en_cnt;
    push_rand(MODE_AND, 0);
    wait_en(base, 50);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_rand(2'(i), 0);
    chk("job_ready_full", job_ready, 0);
    acc = 0;
    job_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (job_ready) acc = 1;
      @(posedge clk); #1;
    end
    job_valid = 0;
    chk("full_blocks_push", acc, 0);
    wait_drain(3000);
    chk("burst_en_pulses", en_cnt - base, 5);

    // Stalled engine aborts via timeout, following job runs normally.
    push_rand(MODE_XOR, 1);
    push_rand(MODE_TWO, 0);
    wait_drain(1500);

    // Downstream backpressure for 20 cycles.
    res_ready = 0;
    push_rand(MODE_A, 0);
    push_rand(MODE_AND, 0);
    acc = 0;
    for (int i = 0; i < 400 && !acc; i++) begin @(negedge clk); if (res_valid) acc = 1; end
    if (!acc) chk("hold_res_valid_timeout", 0, 1);
    sc = res_candidate; se = res_err; base = en_cnt; stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!res_valid || res_candidate !== sc || res_err !== se) stable = 0;
    end
    chk("hold_res_stable", stable, 1);
    chk("hold_no_new_en", en_cnt - base, 0);
    @(posedge clk); #1 res_ready = 1;
    wait_drain(1000);

    // Randomised jobs over all modes with random backpressure.
    bp_en = 1;
    for (int i = 0; i < 16; i++) push_rand(2'(i), 0);
    wait_drain(6000);
    bp_en = 0;
    res_ready = 1;

    // Spurious valid while idle must not produce a result.
    jd = jobs_done;
    inject = 1;
    repeat (10) @(negedge clk);
    chk("spurious_no_res_valid", res_valid, 0);
    chk("spurious_jobs_done", jobs_done, jd);

    // Asynchronous reset mid-HOLD with jobs still queued.
    base = en_cnt;
    push_rand(MODE_A, 0);
    push_rand(MODE_AND, 0);
    push_rand(MODE_XOR, 0);
    wait_en(base, 50);
    repeat (10) @(posedge clk);
    #3 rst = 0;
    exp_q.delete();
    stall_q.delete();
    #1 chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    base = en_cnt;
    repeat (6) @(negedge clk);
    chk("fifo_discarded", en_cnt - base, 0);
    @(posedge clk); #1;
    push_rand(MODE_TWO, 0);
    wait_drain(400);
    chk("post_reset_jobs_done", jobs_done, 1);

    chk("protocol_violations", proto_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
